// File: rtl/n2_iq.sv
// Two-wide instruction queue between fetch and decode: stores fetch responses,
// presents head and head+1, and drops responses that were in flight at a redirect.
module n2_iq #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush_i,
  input  logic          resp_v_i,
  input  logic [1:0]    resp_2b_i,
  input  logic [31:0]   resp_pc_i,
  input  logic [63:0]   resp_rdata_i,
  input  logic [1:0]    resp_pred_i,
  input  logic [PW-1:0] iq_prefetch_ptr_i,
  output logic [PW-1:0] iq_rd_ptr_o,
  output logic [1:0]    iq_v_o,
  output logic [31:0]   iq_instr0_o,
  output logic [31:0]   iq_instr1_o,
  output logic [31:0]   iq_pc0_o,
  output logic [31:0]   iq_pc1_o,
  output logic          iq_pred0_o,
  output logic          iq_pred1_o,
  input  logic [1:0]    dec_take_i
);

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic          pred_q  [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] drop_cnt;

  logic [PW-1:0] occ;
  logic [PW-1:0] nslots;
  logic [PW-1:0] ntake;
  logic [PW-1:0] wr_ptr_inc;
  logic [PW-1:0] rd_ptr_inc;
  logic          wr_en;
  logic [31:0]   s0_instr;
  logic [31:0]   s1_instr;
  logic [31:0]   s1_pc;

  always_comb begin
    nslots     = resp_2b_i[1] ? PW'(2) : PW'(1);
    ntake      = PW'(dec_take_i[0]) + PW'(dec_take_i[1]);
    occ        = wr_ptr - rd_ptr;
    wr_ptr_inc = wr_ptr + PW'(1);
    rd_ptr_inc = rd_ptr + PW'(1);
    wr_en      = resp_v_i && !flush_i && (drop_cnt == '0);
    // A lone slot sits in the upper word when the fetch address is odd-word aligned
    s0_instr   = (resp_2b_i[1] || !resp_pc_i[2]) ? resp_rdata_i[31:0] : resp_rdata_i[63:32];
    s1_instr   = resp_rdata_i[63:32];
    s1_pc      = resp_pc_i + 32'd4;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      drop_cnt <= '0;
    end else if (flush_i) begin
      // Everything fetch allocated beyond wr_ptr is still in flight and must be dropped;
      // a response arriving in the flush cycle is one of those and already accounted.
      rd_ptr   <= iq_prefetch_ptr_i;
      wr_ptr   <= iq_prefetch_ptr_i;
      drop_cnt <= iq_prefetch_ptr_i - wr_ptr - (resp_v_i ? nslots : '0);
    end else begin
      rd_ptr <= rd_ptr + ntake;
      if (resp_v_i) begin
        if (drop_cnt != '0) begin
          drop_cnt <= drop_cnt - nslots;
        end else begin
          wr_ptr <= wr_ptr + nslots;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        pred_q[i]  <= 1'b0;
      end
    end else if (wr_en) begin
      instr_q[wr_ptr[AW-1:0]] <= s0_instr;
      pc_q[wr_ptr[AW-1:0]]    <= resp_pc_i;
      pred_q[wr_ptr[AW-1:0]]  <= resp_pred_i[0];
      if (resp_2b_i[1]) begin
        instr_q[wr_ptr_inc[AW-1:0]] <= s1_instr;
        pc_q[wr_ptr_inc[AW-1:0]]    <= s1_pc;
        pred_q[wr_ptr_inc[AW-1:0]]  <= resp_pred_i[1];
      end
    end
  end

  always_comb begin
    iq_rd_ptr_o = rd_ptr;
    iq_v_o[0]   = (occ != '0);
    iq_v_o[1]   = (occ >= PW'(2));
    iq_instr0_o = instr_q[rd_ptr[AW-1:0]];
    iq_pc0_o    = pc_q[rd_ptr[AW-1:0]];
    iq_pred0_o  = pred_q[rd_ptr[AW-1:0]];
    iq_instr1_o = instr_q[rd_ptr_inc[AW-1:0]];
    iq_pc1_o    = pc_q[rd_ptr_inc[AW-1:0]];
    iq_pred1_o  = pred_q[rd_ptr_inc[AW-1:0]];
  end

`ifndef SYNTHESIS
  a_take_subset: assert property (@(posedge clk) disable iff (!resetn)
    !flush_i |-> ((dec_take_i & ~iq_v_o) == 2'b00));
  a_take_shape: assert property (@(posedge clk) disable iff (!resetn)
    !flush_i |-> (dec_take_i != 2'b10));
  a_resp_mask: assert property (@(posedge clk) disable iff (!resetn)
    resp_v_i |-> ((resp_2b_i == 2'b01) || (resp_2b_i == 2'b11 && !resp_pc_i[2])));
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    (wr_en) |-> (int'(occ) - int'(ntake) + int'(nslots) <= DEPTH));
`endif

endmodule

// File: tb/tb_n2_iq.sv
// Directed bench for n2_iq: stimulus pushes expected {instr,pc,pred} records,
// a negedge monitor pops and compares them whenever decode takes an entry.
module tb_n2_iq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush_i;
  logic        resp_v_i;
  logic [1:0]  resp_2b_i;
  logic [31:0] resp_pc_i;
  logic [63:0] resp_rdata_i;
  logic [1:0]  resp_pred_i;
  logic [2:0]  iq_prefetch_ptr_i;
  logic [2:0]  iq_rd_ptr_o;
  logic [1:0]  iq_v_o;
  logic [31:0] iq_instr0_o, iq_instr1_o, iq_pc0_o, iq_pc1_o;
  logic        iq_pred0_o, iq_pred1_o;
  logic [1:0]  dec_take_i;

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q [$];

  n2_iq #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .flush_i(flush_i), .resp_v_i(resp_v_i),
    .resp_2b_i(resp_2b_i), .resp_pc_i(resp_pc_i), .resp_rdata_i(resp_rdata_i),
    .resp_pred_i(resp_pred_i), .iq_prefetch_ptr_i(iq_prefetch_ptr_i),
    .iq_rd_ptr_o(iq_rd_ptr_o), .iq_v_o(iq_v_o),
    .iq_instr0_o(iq_instr0_o), .iq_instr1_o(iq_instr1_o),
    .iq_pc0_o(iq_pc0_o), .iq_pc1_o(iq_pc1_o),
    .iq_pred0_o(iq_pred0_o), .iq_pred1_o(iq_pred1_o),
    .dec_take_i(dec_take_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic pred);
    exp_q.push_back({instr, pc, pred});
  endtask

  // One cycle of stimulus; returns 1 time unit after the capturing edge.
  task automatic cyc(input logic fl, input logic rv, input logic [1:0] m,
                     input logic [31:0] pc, input logic [63:0] rd,
                     input logic [1:0] pr, input logic [2:0] pf, input logic [1:0] tk);
    flush_i = fl; resp_v_i = rv; resp_2b_i = m; resp_pc_i = pc;
    resp_rdata_i = rd; resp_pred_i = pr; iq_prefetch_ptr_i = pf; dec_take_i = tk;
    @(posedge clk);
    #1;
    flush_i = 1'b0; resp_v_i = 1'b0; resp_2b_i = 2'b01; dec_take_i = 2'b00;
  endtask

  task automatic chk_head(input string nm, input logic [1:0] v, input logic [2:0] rp,
                          input logic [31:0] i0, input logic [31:0] p0);
    chk({nm, "_v"}, iq_v_o, v);
    chk({nm, "_rdptr"}, iq_rd_ptr_o, rp);
    if (v[0]) begin
      chk({nm, "_instr0"}, iq_instr0_o, i0);
      chk({nm, "_pc0"}, iq_pc0_o, p0);
    end
  endtask

  // Monitor: every taken slot must match the oldest expected record.
  always @(negedge clk) begin
    if (resetn && !flush_i) begin
      chk("v_order", {1'b0, iq_v_o[1] & ~iq_v_o[0]}, 2'b00);
      if (dec_take_i[0]) begin
        if (exp_q.size() == 0) chk("pop0_empty", 1, 0);
        else chk("slot0", {iq_instr0_o, iq_pc0_o, iq_pred0_o}, exp_q.pop_front());
      end
      if (dec_take_i[1]) begin
        if (exp_q.size() == 0) chk("pop1_empty", 1, 0);
        else chk("slot1", {iq_instr1_o, iq_pc1_o, iq_pred1_o}, exp_q.pop_front());
      end
    end
  end

  initial begin
    resetn = 1'b0; flush_i = 1'b0; resp_v_i = 1'b0; resp_2b_i = 2'b01;
    resp_pc_i = '0; resp_rdata_i = '0; resp_pred_i = '0;
    iq_prefetch_ptr_i = '0; dec_take_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v", iq_v_o, 2'b00);
    chk("rst_rdptr", iq_rd_ptr_o, 3'd0);
    chk("rst_instr0", iq_instr0_o, 32'h0);
    chk("rst_pc0", iq_pc0_o, 32'h0);
    chk("rst_instr1", iq_instr1_o, 32'h0);
    chk("rst_pred", {iq_pred1_o, iq_pred0_o}, 2'b00);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Dual-slot response, visible one cycle later
    push(32'hAAAAAAAA, 32'h100, 1'b0); push(32'hBBBBBBBB, 32'h104, 1'b0);
    cyc(0, 1, 2'b11, 32'h100, 64'hBBBBBBBB_AAAAAAAA, 2'b00, 3'd0, 2'b00);
    chk_head("dual", 2'b11, 3'd0, 32'hAAAAAAAA, 32'h100);
    chk("dual_instr1", iq_instr1_o, 32'hBBBBBBBB);
    chk("dual_pc1", iq_pc1_o, 32'h104);

    // Single slot from upper word, same cycle as a take of both heads
    push(32'h12345678, 32'h10C, 1'b1);
    cyc(0, 1, 2'b01, 32'h10C, 64'h12345678_00000000, 2'b01, 3'd0, 2'b11);
    chk_head("single_hi", 2'b01, 3'd2, 32'h12345678, 32'h10C);
    chk("single_hi_pred", iq_pred0_o, 1'b1);

    // Single slot from lower word; pred taken from bit 0 only
    push(32'hCAFEF00D, 32'h110, 1'b0);
    cyc(0, 1, 2'b01, 32'h110, 64'h00000000_CAFEF00D, 2'b10, 3'd0, 2'b01);
    chk_head("single_lo", 2'b01, 3'd3, 32'hCAFEF00D, 32'h110);
    chk("single_lo_pred", iq_pred0_o, 1'b0);

    // Fill to four entries, then take two while writing two, twice
    push(32'h11111111, 32'h200, 1'b0); push(32'h22222222, 32'h204, 1'b1);
    cyc(0, 1, 2'b11, 32'h200, 64'h22222222_11111111, 2'b10, 3'd0, 2'b01);
    push(32'h33333333, 32'h208, 1'b1); push(32'h44444444, 32'h20C, 1'b0);
    cyc(0, 1, 2'b11, 32'h208, 64'h44444444_33333333, 2'b01, 3'd0, 2'b00);
    chk_head("full", 2'b11, 3'd4, 32'h11111111, 32'h200);
    push(32'h55555555, 32'h210, 1'b0); push(32'h66666666, 32'h214, 1'b0);
    cyc(0, 1, 2'b11, 32'h210, 64'h66666666_55555555, 2'b00, 3'd0, 2'b11);
    chk_head("full_tw1", 2'b11, 3'd6, 32'h33333333, 32'h208);
    chk("full_tw1_pc1", iq_pc1_o, 32'h20C);
    push(32'h77777777, 32'h218, 1'b0); push(32'h88888888, 32'h21C, 1'b0);
    cyc(0, 1, 2'b11, 32'h218, 64'h88888888_77777777, 2'b00, 3'd0, 2'b11);
    chk_head("wrap", 2'b11, 3'd0, 32'h55555555, 32'h210);
    chk("wrap_instr1", iq_instr1_o, 32'h66666666);
    chk("wrap_pc1", iq_pc1_o, 32'h214);

    // Asynchronous reset with a full queue discards everything
    resetn = 1'b0;
    #2;
    chk_head("midrst", 2'b00, 3'd0, 32'h0, 32'h0);
    chk("midrst_instr0", iq_instr0_o, 32'h0);
    chk("midrst_pc0", iq_pc0_o, 32'h0);
    exp_q.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Two slots outstanding at flush (take ignored in the flush cycle)
    cyc(0, 1, 2'b11, 32'h300, 64'hB0B0B0B0_A0A0A0A0, 2'b00, 3'd4, 2'b00);
    chk_head("preflush", 2'b11, 3'd0, 32'hA0A0A0A0, 32'h300);
    cyc(1, 0, 2'b01, 32'h0, 64'h0, 2'b00, 3'd4, 2'b11);
    exp_q.delete();
    chk_head("flush", 2'b00, 3'd4, 32'h0, 32'h0);
    cyc(0, 1, 2'b11, 32'h308, 64'hD2D2D2D2_D1D1D1D1, 2'b00, 3'd4, 2'b00);
    chk_head("dropped", 2'b00, 3'd4, 32'h0, 32'h0);
    push(32'hD00DD00D, 32'h400, 1'b1);
    cyc(0, 1, 2'b01, 32'h400, 64'h00000000_D00DD00D, 2'b01, 3'd5, 2'b00);
    chk_head("postdrop", 2'b01, 3'd4, 32'hD00DD00D, 32'h400);
    cyc(0, 0, 2'b01, 32'h0, 64'h0, 2'b00, 3'd7, 2'b01);
    chk_head("postdrop_take", 2'b00, 3'd5, 32'h0, 32'h0);

    // Flush with a same-cycle response: that response counts against the drop
    cyc(1, 1, 2'b01, 32'h410, 64'h00000000_E1E1E1E1, 2'b00, 3'd7, 2'b00);
    exp_q.delete();
    chk_head("flush_resp", 2'b00, 3'd7, 32'h0, 32'h0);
    cyc(0, 1, 2'b01, 32'h414, 64'hE2E2E2E2_00000000, 2'b00, 3'd7, 2'b00);
    chk_head("flush_resp_drop", 2'b00, 3'd7, 32'h0, 32'h0);
    push(32'hE3E3E3E3, 32'h500, 1'b1); push(32'hE4E4E4E4, 32'h504, 1'b1);
    cyc(0, 1, 2'b11, 32'h500, 64'hE4E4E4E4_E3E3E3E3, 2'b11, 3'd1, 2'b00);
    chk_head("wrap_write", 2'b11, 3'd7, 32'hE3E3E3E3, 32'h500);
    chk("wrap_write_instr1", iq_instr1_o, 32'hE4E4E4E4);
    chk("wrap_write_pc1", iq_pc1_o, 32'h504);
    cyc(0, 0, 2'b01, 32'h0, 64'h0, 2'b00, 3'd3, 2'b11);
    chk_head("wrap_take", 2'b00, 3'd1, 32'h0, 32'h0);

    // Back-to-back flushes: drop count is recomputed, not accumulated
    cyc(1, 0, 2'b01, 32'h0, 64'h0, 2'b00, 3'd3, 2'b00);
    cyc(1, 0, 2'b01, 32'h0, 64'h0, 2'b00, 3'd5, 2'b00);
    exp_q.delete();
    chk_head("reflush", 2'b00, 3'd5, 32'h0, 32'h0);
    cyc(0, 1, 2'b11, 32'h608, 64'hF2F2F2F2_F1F1F1F1, 2'b00, 3'd5, 2'b00);
    chk_head("reflush_drop", 2'b00, 3'd5, 32'h0, 32'h0);
    push(32'hF0F0F0F0, 32'h600, 1'b0);
    cyc(0, 1, 2'b01, 32'h600, 64'h00000000_F0F0F0F0, 2'b00, 3'd6, 2'b00);
    chk_head("reflush_write", 2'b01, 3'd5, 32'hF0F0F0F0, 32'h600);
    cyc(0, 0, 2'b01, 32'h0, 64'h0, 2'b00, 3'd6, 2'b01);
    chk_head("final", 2'b00, 3'd6, 32'h0, 32'h0);

    @(posedge clk); #1;
    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
